// File: rtl/siso_input_framer.sv
// Input framer for the SISO decoder core: captures one trellis block
// (systematic, parity and a-priori LLRs plus tail steps) and replays it forward or reverse.
module siso_input_framer #(
    parameter int DATA_W  = 16,
    parameter int MAX_BLK = 6144,
    parameter int TAIL    = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [15:0]       blklen_i,
    input  logic              valid_blklen_i,
    input  logic [DATA_W-1:0] in_i,
    input  logic              valid_in_i,
    input  logic [DATA_W-1:0] apriori_i,
    input  logic              valid_apriori_i,
    output logic              ready_o,
    input  logic              start_read_i,
    input  logic              dir_i,
    input  logic              release_i,
    output logic [DATA_W-1:0] out_sys_o,
    output logic [DATA_W-1:0] out_par_o,
    output logic [DATA_W-1:0] out_apr_o,
    output logic [15:0]       out_idx_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_last_o,
    output logic              full_o,
    output logic              err_len_o,
    output logic              err_ovf_o
);
    localparam int          DEPTH     = MAX_BLK + TAIL;
    localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [15:0] MAX_BLK_W = 16'(MAX_BLK);
    localparam logic [15:0] TAIL_W    = 16'(TAIL);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FULL = 2'd2,
        ST_READ = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [15:0] k_q, k_d;
    logic [15:0] smp_cnt_q, smp_cnt_d;
    logic [15:0] apr_cnt_q, apr_cnt_d;
    logic [15:0] rd_idx_q, rd_idx_d;
    logic [15:0] rd_left_q, rd_left_d;
    logic        dir_q, dir_d;
    logic        ready_q, ready_d;
    logic        full_q, full_d;
    logic        err_len_q, err_len_d;
    logic        err_ovf_q, err_ovf_d;
    logic        out_valid_q, out_valid_d;
    logic        out_last_q, out_last_d;
    logic [15:0] out_idx_q, out_idx_d;
    logic [DATA_W-1:0] out_sys_q, out_par_q, out_apr_q;

    logic [DATA_W-1:0] sys_mem [DEPTH];
    logic [DATA_W-1:0] par_mem [DEPTH];
    logic [DATA_W-1:0] apr_mem [DEPTH];

    logic        blk_ok_s;
    logic [15:0] smp_tgt_s;
    logic        in_acc_s;
    logic        apr_acc_s;
    logic        ovf_s;
    logic        handshake_s;
    logic        fetch_s;
    logic [AW-1:0] wr_addr_s;
    logic [AW-1:0] apr_addr_s;
    logic [AW-1:0] rd_addr_s;

    assign blk_ok_s    = (blklen_i != 16'd0) && (blklen_i <= MAX_BLK_W);
    assign smp_tgt_s   = {n_q[14:0], 1'b0};
    assign in_acc_s    = (state_q == ST_LOAD) && valid_in_i && (smp_cnt_q < smp_tgt_s);
    assign apr_acc_s   = (state_q == ST_LOAD) && valid_apriori_i && (apr_cnt_q < k_q);
    assign ovf_s       = (valid_in_i && !in_acc_s) || (valid_apriori_i && !apr_acc_s);
    assign handshake_s = out_valid_q && out_ready_i;
    // The output registers double as the RAM read register, so a fetch only
    // happens when they are empty or being drained this cycle.
    assign fetch_s     = (state_q == ST_READ) && (rd_left_q != 16'd0) &&
                         (!out_valid_q || out_ready_i);
    assign wr_addr_s   = smp_cnt_q[AW:1];
    assign apr_addr_s  = apr_cnt_q[AW-1:0];
    assign rd_addr_s   = rd_idx_q[AW-1:0];

    // Next-state and control-register logic.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        k_d         = k_q;
        smp_cnt_d   = smp_cnt_q;
        apr_cnt_d   = apr_cnt_q;
        rd_idx_d    = rd_idx_q;
        rd_left_d   = rd_left_q;
        dir_d       = dir_q;
        err_len_d   = 1'b0;
        err_ovf_d   = err_ovf_q | ovf_s;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_idx_d   = out_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_blklen_i && blk_ok_s) begin
                    state_d   = ST_LOAD;
                    n_d       = blklen_i + TAIL_W;
                    k_d       = blklen_i;
                    smp_cnt_d = 16'd0;
                    apr_cnt_d = 16'd0;
                    err_ovf_d = ovf_s;
                end else if (valid_blklen_i) begin
                    err_len_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                smp_cnt_d = smp_cnt_q + {15'd0, in_acc_s};
                apr_cnt_d = apr_cnt_q + {15'd0, apr_acc_s};
                if ((smp_cnt_d == smp_tgt_s) && (apr_cnt_d == k_q)) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_FULL: begin
                if (release_i) begin
                    state_d = ST_IDLE;
                end else if (start_read_i) begin
                    state_d   = ST_READ;
                    dir_d     = dir_i;
                    rd_idx_d  = dir_i ? (n_q - 16'd1) : 16'd0;
                    rd_left_d = n_q;
                end else begin
                    state_d = ST_FULL;
                end
            end
            ST_READ: begin
                if (fetch_s) begin
                    rd_idx_d    = dir_q ? (rd_idx_q - 16'd1) : (rd_idx_q + 16'd1);
                    rd_left_d   = rd_left_q - 16'd1;
                    out_valid_d = 1'b1;
                    out_idx_d   = rd_idx_q;
                    out_last_d  = (rd_left_q == 16'd1);
                end else if (handshake_s) begin
                    out_valid_d = 1'b0;
                end else begin
                    out_valid_d = out_valid_q;
                end
                if (handshake_s && out_last_q) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        full_d  = (state_d == ST_FULL);
    end

    // Control and status registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            n_q         <= 16'd0;
            k_q         <= 16'd0;
            smp_cnt_q   <= 16'd0;
            apr_cnt_q   <= 16'd0;
            rd_idx_q    <= 16'd0;
            rd_left_q   <= 16'd0;
            dir_q       <= 1'b0;
            ready_q     <= 1'b1;
            full_q      <= 1'b0;
            err_len_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_idx_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            n_q         <= n_d;
            k_q         <= k_d;
            smp_cnt_q   <= smp_cnt_d;
            apr_cnt_q   <= apr_cnt_d;
            rd_idx_q    <= rd_idx_d;
            rd_left_q   <= rd_left_d;
            dir_q       <= dir_d;
            ready_q     <= ready_d;
            full_q      <= full_d;
            err_len_q   <= err_len_d;
            err_ovf_q   <= err_ovf_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_idx_q   <= out_idx_d;
        end
    end

    // Even samples are systematic, odd samples parity, both for step smp_cnt/2.
    always_ff @(posedge clk_i) begin
        if (in_acc_s && !smp_cnt_q[0]) begin
            sys_mem[wr_addr_s] <= in_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (in_acc_s && smp_cnt_q[0]) begin
            par_mem[wr_addr_s] <= in_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (apr_acc_s) begin
            apr_mem[apr_addr_s] <= apriori_i;
        end
    end

    // Registered RAM read; tail steps carry no a-priori information.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_sys_q <= {DATA_W{1'b0}};
            out_par_q <= {DATA_W{1'b0}};
            out_apr_q <= {DATA_W{1'b0}};
        end else if (fetch_s) begin
            out_sys_q <= sys_mem[rd_addr_s];
            out_par_q <= par_mem[rd_addr_s];
            out_apr_q <= (rd_idx_q < k_q) ? apr_mem[rd_addr_s] : {DATA_W{1'b0}};
        end
    end

    assign ready_o     = ready_q;
    assign full_o      = full_q;
    assign err_len_o   = err_len_q;
    assign err_ovf_o   = err_ovf_q;
    assign out_valid_o = out_valid_q;
    assign out_last_o  = out_last_q;
    assign out_idx_o   = out_idx_q;
    assign out_sys_o   = out_sys_q;
    assign out_par_o   = out_par_q;
    assign out_apr_o   = out_apr_q;

endmodule

// File: tb/tb_siso_input_framer.sv
// Randomised self-checking bench for siso_input_framer against a block-level
// reference model (arrays of loaded samples, expected replay order).
module tb_siso_input_framer;
    localparam int DATA_W  = 16;
    localparam int MAX_BLK = 6144;
    localparam int TAIL    = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [15:0]       blklen = 16'd0;
    logic              valid_blklen = 1'b0;
    logic [DATA_W-1:0] din = 16'd0;
    logic              valid_in = 1'b0;
    logic [DATA_W-1:0] apriori = 16'd0;
    logic              valid_apriori = 1'b0;
    logic              ready;
    logic              start_read = 1'b0;
    logic              dir = 1'b0;
    logic              rel = 1'b0;
    logic [DATA_W-1:0] out_sys, out_par, out_apr;
    logic [15:0]       out_idx;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
    logic              full;
    logic              err_len;
    logic              err_ovf;

    always #5 clk = ~clk;

    siso_input_framer #(.DATA_W(DATA_W), .MAX_BLK(MAX_BLK), .TAIL(TAIL)) dut (
        .clk_i(clk), .rst_i(rst),
        .blklen_i(blklen), .valid_blklen_i(valid_blklen),
        .in_i(din), .valid_in_i(valid_in),
        .apriori_i(apriori), .valid_apriori_i(valid_apriori),
        .ready_o(ready), .start_read_i(start_read), .dir_i(dir), .release_i(rel),
        .out_sys_o(out_sys), .out_par_o(out_par), .out_apr_o(out_apr),
        .out_idx_o(out_idx), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_last_o(out_last), .full_o(full), .err_len_o(err_len), .err_ovf_o(err_ovf)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cur_k  = 0;
    logic [15:0] mdl_in [0:2*(MAX_BLK+TAIL)-1];
    logic [15:0] mdl_ap [0:MAX_BLK-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_apr(input int i);
        return (i < cur_k) ? mdl_ap[i] : 16'd0;
    endfunction

    task automatic load_block(input int k, input bit ramp, input bit inject);
        int n2, si, ai, cyc;
        bit early_full;
        cur_k = k; n2 = 2 * (k + TAIL); si = 0; ai = 0; cyc = 0; early_full = 1'b0;
        for (int i = 0; i < n2; i++) mdl_in[i] = ramp ? 16'(i) : 16'($urandom);
        for (int j = 0; j < k; j++) mdl_ap[j] = ramp ? 16'(1000 + j) : 16'($urandom);
        @(negedge clk);
        blklen = 16'(k); valid_blklen = 1'b1;
        @(negedge clk);
        valid_blklen = 1'b0;
        check("ld_ready_low", 32'(ready), 32'd0);
        check("ld_ovf_clear", 32'(err_ovf), 32'd0);
        while ((si < n2 || ai < k) && cyc < 40000) begin
            valid_in = (si < n2) && (ramp || ($urandom_range(0, 3) != 0));
            if (si < n2) din = mdl_in[si];
            else         din = 16'd0;
            valid_apriori = (ai < k) && (ramp ? (cyc % 2 == 0) : ($urandom_range(0, 1) == 1));
            if (ai < k) apriori = mdl_ap[ai];
            else        apriori = 16'd0;
            valid_blklen = inject && (cyc == 3);
            blklen = 16'd5;
            early_full |= full;
            @(negedge clk);
            if (valid_in) si++;
            if (valid_apriori) ai++;
            cyc++;
        end
        valid_in = 1'b0; valid_apriori = 1'b0; valid_blklen = 1'b0;
        check("ld_no_early_full", 32'(early_full), 32'd0);
        check("ld_full", 32'(full), 32'd1);
        check("ld_no_ovf", 32'(err_ovf), 32'd0);
    endtask

    task automatic read_pass(input bit d, input bit rnd, input int abort_idx);
        int n, s, cyc, idx;
        n = cur_k + TAIL; s = 0; cyc = 0;
        @(negedge clk);
        start_read = 1'b1; dir = d; out_ready = 1'b0;
        @(negedge clk);
        start_read = 1'b0;
        check("rd_lat1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("rd_lat2_valid", 32'(out_valid), 32'd1);
        while (s < n && cyc < 8 * n + 16) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                idx = d ? (n - 1 - s) : s;
                check("rd_idx", 32'(out_idx), idx);
                check("rd_sys", 32'(out_sys), 32'(mdl_in[2 * idx]));
                check("rd_par", 32'(out_par), 32'(mdl_in[2 * idx + 1]));
                check("rd_apr", 32'(out_apr), 32'(exp_apr(idx)));
                check("rd_last", 32'(out_last), (s == n - 1) ? 32'd1 : 32'd0);
                if (idx == abort_idx) begin
                    rst = 1'b1; out_ready = 1'b0;
                    @(negedge clk);
                    check("abort_valid", 32'(out_valid), 32'd0);
                    check("abort_ready", 32'(ready), 32'd1);
                    check("abort_full", 32'(full), 32'd0);
                    rst = 1'b0;
                    return;
                end
                if (out_ready) s++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        check("rd_handshakes", s, n);
        check("rd_valid_drop", 32'(out_valid), 32'd0);
        check("rd_full_back", 32'(full), 32'd1);
    endtask

    task automatic release_block();
        @(negedge clk);
        rel = 1'b1;
        @(negedge clk);
        rel = 1'b0;
        check("rel_ready", 32'(ready), 32'd1);
        check("rel_full", 32'(full), 32'd0);
    endtask

    initial begin
        int bad_len [2];
        bad_len[0] = 0;
        bad_len[1] = MAX_BLK + 1;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        check("rst_sys", 32'(out_sys), 32'd0);
        check("rst_err_len", 32'(err_len), 32'd0);
        check("rst_err_ovf", 32'(err_ovf), 32'd0);
        rst = 1'b0;

        load_block(512, 1'b1, 1'b0);
        read_pass(1'b0, 1'b0, -1);
        read_pass(1'b1, 1'b0, -1);
        read_pass(1'b0, 1'b0, -1);
        release_block();

        load_block(MAX_BLK, 1'b0, 1'b0);
        read_pass(1'b0, 1'b1, -1);
        release_block();

        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            blklen = 16'(bad_len[b]); valid_blklen = 1'b1;
            @(negedge clk);
            valid_blklen = 1'b0;
            check("badlen_err", 32'(err_len), 32'd1);
            check("badlen_ready", 32'(ready), 32'd1);
            @(negedge clk);
            check("badlen_pulse", 32'(err_len), 32'd0);
            check("badlen_idle", 32'(ready), 32'd1);
            check("badlen_full", 32'(full), 32'd0);
        end

        load_block(16, 1'b0, 1'b1);
        @(negedge clk);
        valid_in = 1'b1; din = 16'hBEEF;
        @(negedge clk);
        valid_in = 1'b0;
        check("ovf_set", 32'(err_ovf), 32'd1);
        check("ovf_full_kept", 32'(full), 32'd1);
        read_pass(1'b1, 1'b1, -1);
        check("ovf_sticky", 32'(err_ovf), 32'd1);
        release_block();

        load_block(512, 1'b0, 1'b0);
        read_pass(1'b0, 1'b0, 100);
        load_block(512, 1'b0, 1'b0);
        read_pass(1'b0, 1'b1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/siso_input_framer.md
Name: siso_input_framer

Overview:
- Parametrised input framer placed in front of the SISO decoder core.
- Accepts a block-length command, then an interleaved systematic/parity LLR stream and an a-priori LLR stream, and stores one trellis block plus tail steps.
- Replays the stored block to the core any number of times, forward (alpha recursion) or reverse (beta recursion), with a valid/ready handshake.
- Generalises the fixed 16-bit, 512/6144 load path to configurable width, depth and tail length, and adds reverse replay.

Parameters:
DATA_W, 16, LLR width (two's complement)
MAX_BLK, 6144, maximum information block length
TAIL, 3, trellis termination steps appended after blklen (0 allowed)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
blklen  in  16  information block length K
valid_blklen  in  1  blklen qualifier, one-cycle pulse
in  in  DATA_W  channel LLR stream, alternating sys, par, sys, par...
valid_in  in  1  in qualifier
apriori  in  DATA_W  a-priori LLR, one per information bit
valid_apriori  in  1  apriori qualifier
ready  out  1  high in IDLE only: framer accepts a new blklen
start_read  in  1  request one replay pass, honoured in FULL only
dir  in  1  sampled with start_read: 0 forward, 1 reverse
release  in  1  in FULL, discard block and return to IDLE
out_sys  out  DATA_W  systematic LLR of current step
out_par  out  DATA_W  parity LLR of current step
out_apr  out  DATA_W  a-priori LLR (0 for tail steps)
out_idx  out  16  trellis step index of current output
out_valid  out  1  output qualifier
out_ready  in  1  downstream accept
out_last  out  1  final step of the pass
full  out  1  high in FULL
err_len  out  1  one-cycle pulse on rejected blklen
err_ovf  out  1  sticky: sample arrived beyond expected count; cleared by rst or next accepted blklen

Behaviour:
- Reset: state IDLE; ready=1; all other outputs 0; counters cleared; RAM contents undefined and not cleared.
- N = blklen + TAIL, latched on accept. Sample counter target 2N; apriori counter target K.
- States:
  - IDLE: valid_blklen with 1 <= blklen <= MAX_BLK -> LOAD, ready=0 next cycle, err_ovf cleared. blklen 0 or > MAX_BLK -> err_len pulse next cycle, stay IDLE.
  - LOAD:
    - Even-numbered in samples go to sys[i], odd-numbered to par[i], i = sample_count>>1.
    - apriori samples fill apr[j] in order and may arrive on the same cycle as in or independently.
    - When both counts reach their targets -> FULL on the following cycle.
  - FULL: full=1.
    - start_read -> READ with latched dir.
    - release -> IDLE.
    - start_read and release together: release wins.
  - READ:
    - Steps 0..N-1 (forward) or N-1..0 (reverse) are presented in sequence.
    - First out_valid appears exactly 2 cycles after the start_read cycle (1 cycle address, 1 cycle registered RAM read).
    - Advances on out_valid && out_ready; sustains one step per cycle with out_ready held high.
    - out_valid low: out_* hold unchanged. out_valid high and out_ready low: out_* hold stable.
    - out_last=1 with the final step. Its handshake -> FULL; out_valid drops the next cycle.
- out_apr = 0 for steps idx >= K. out_idx is the true step index in both directions.
- Error and ignore rules:
  - valid_in or valid_apriori beyond its target, or outside LOAD: sample dropped, err_ovf set.
  - valid_blklen outside IDLE: ignored, no error.
  - start_read outside FULL: ignored.
- Reset mid-LOAD or mid-READ: IDLE the next cycle; out_valid=0 immediately (registered); partial block discarded.
- No arithmetic on data; widths pass through unchanged. Index counters are 16-bit.
- Memory: three single-port-read/single-port-write arrays of depth MAX_BLK+TAIL, inferred RAM.

Test Plan:
- Reset then blklen=512, TAIL=3: 1030 ramp in samples (value = sample index), 512 apriori (value = 1000+j) on alternate cycles. Required: full=1 one cycle after last sample. Forward pass: out_sys[i]=2i, out_par[i]=2i+1, out_apr[i]=1000+i for i<512, out_apr=0 for i=512..514, out_last at idx 514, first out_valid 2 cycles after start_read.
- Same block, start_read with dir=1. Required: first output idx 514 with sys=1028, par=1029, apr=0; last output idx 0, out_last=1. A second forward pass afterwards returns identical data.
- blklen=6144, random out_ready (50% duty) during forward pass. Required: no step skipped or duplicated, data stable while stalled, exactly 6147 handshakes.
- blklen=0, then blklen=6145. Required: err_len pulses once for each, ready stays 1, state stays IDLE. Then valid_blklen while in LOAD: ignored.
- After load of blklen=16, inject one extra valid_in in FULL. Required: err_ovf=1, stored data unchanged. Next accepted blklen clears err_ovf.
- Assert rst mid-READ at idx 100 of a 512 block. Required: out_valid=0 the next cycle, ready=1, full=0. A new blklen load then completes normally.
